// File: rtl/screen_scanner.sv
// Raster scanner for a 512x256 monochrome screen mapped at 0x4000-0x5FFF.
// Keeps one word prefetched ahead of the beam; missing words show as blank.
module screen_scanner #(
  parameter int H_BLANK = 32,
  parameter int V_BLANK = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic        rd_req,
  output logic [14:0] rd_addr,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic        pixel,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        underrun
);

  localparam int XMAX = 511 + H_BLANK;
  localparam int YMAX = 255 + V_BLANK;
  localparam int XW = $clog2(XMAX + 1);
  localparam int YW = $clog2(YMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } st_t;

  st_t st, st_nx;

  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic [15:0]   sr, buf_q, lw;
  logic [13:0]   fp;
  logic [12:0]   w;
  logic          buf_v, drop, ign;
  logic          xwrap, nact, ldpt;
  logic          take, direct, under, vb_start;

  always_comb begin
    xwrap = (x == XW'(XMAX));
    nx    = xwrap ? '0 : x + 1'b1;
    ny    = y;
    if (xwrap)
      ny = (y == YW'(YMAX)) ? '0 : y + 1'b1;
    nact     = (nx < XW'(512)) && (ny < YW'(256));
    ldpt     = enable && nact && (nx[3:0] == 4'd0);
    w        = {ny[7:0], nx[8:4]};
    take     = (st == WAIT) && rd_valid && !drop;
    direct   = ldpt && !buf_v && take;
    under    = ldpt && !buf_v && !take;
    lw       = buf_v ? buf_q : (take ? rd_data : '0);
    vb_start = enable && xwrap && (y == YW'(255));
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:
        if (enable && !ign && !buf_v && !fp[13])
          st_nx = REQ;
      REQ:
        if (enable)
          st_nx = WAIT;
      WAIT:
        if (rd_valid)
          st_nx = IDLE;
      default:
        st_nx = IDLE;
    endcase
  end

  assign rd_req  = (st == REQ) && enable;
  assign rd_addr = {2'b10, fp[12:0]};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st          <= IDLE;
      x           <= '0;
      y           <= YW'(256);
      sr          <= '0;
      buf_q       <= '0;
      buf_v       <= 1'b0;
      drop        <= 1'b0;
      ign         <= 1'b1;
      fp          <= '0;
      pixel       <= 1'b0;
      active      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      st  <= st_nx;
      ign <= 1'b0;
      if (take && !direct) begin
        buf_q <= rd_data;
        buf_v <= 1'b1;
      end
      if (ldpt)
        buf_v <= 1'b0;
      // a request still in flight at an underrun carries a stale word
      if (st == WAIT && rd_valid)
        drop <= 1'b0;
      if (under && (st == REQ || (st == WAIT && !rd_valid)))
        drop <= 1'b1;
      if (vb_start)
        fp <= '0;
      else if (under)
        fp <= 14'(w) + 14'd1;
      else if (rd_req)
        fp <= fp + 14'd1;
      if (enable) begin
        x           <= nx;
        y           <= ny;
        active      <= nact;
        hsync       <= (nx >= XW'(512));
        vsync       <= (ny >= YW'(256));
        frame_start <= (nx == '0) && (ny == '0);
        if (ldpt) begin
          sr    <= lw;
          pixel <= lw[0];
        end else begin
          pixel <= nact && sr[nx[3:0]];
        end
        if (under)
          underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_screen_scanner.sv
// Bench for screen_scanner: random memory/latency/enable against a
// transaction-level model of beam position and word arrival times.
module tb_screen_scanner;

  localparam int HB = 32;
  localparam int VB = 8;
  localparam int XT = 512 + HB;
  localparam int YT = 256 + VB;
  localparam int NEVER = 32'h7fffffff;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        rd_req;
  logic [14:0] rd_addr;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = '0;
  logic        pixel, active, hsync, vsync, frame_start, underrun;

  screen_scanner #(.H_BLANK(HB), .V_BLANK(VB)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .pixel(pixel),
    .active(active),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start),
    .underrun(underrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    int idx;
  } rsp_t;

  logic [15:0] mem[8192];
  int          arrival[8192];
  rsp_t        pend[$];
  int          ec = 0;
  int          px = 0, py = 256;
  logic [15:0] cur = '0;
  bit          exp_under = 1'b0;
  int          tests = 0, fails = 0;
  int          lat_force = 0, lat_max = 1;
  int          addr_bad = 0;
  bit          last_req = 1'b0;
  bit          checking = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit en, input int e);
    int w;
    if (rst) begin
      px = 0;
      py = 256;
      cur = '0;
      exp_under = 1'b0;
      for (int i = 0; i < 8192; i++) arrival[i] = NEVER;
    end else if (en) begin
      px++;
      if (px == XT) begin
        px = 0;
        py++;
        if (py == YT) py = 0;
      end
      if (px < 512 && py < 256 && px % 16 == 0) begin
        w = py * 32 + px / 16;
        if (arrival[w] <= e) begin
          cur = mem[w];
        end else begin
          cur = '0;
          exp_under = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic ea, eh, ev, ef, ep;
    ea = (px < 512) && (py < 256);
    eh = (px >= 512);
    ev = (py >= 256);
    ef = (px == 0) && (py == 0);
    ep = ea && cur[px % 16];
    tests++;
    if ({pixel, active, hsync, vsync, frame_start, underrun} !==
        {ep, ea, eh, ev, ef, exp_under}) begin
      fails++;
      $display("FAIL scan edge %0d (x=%0d,y=%0d): pix/act/hs/vs/fs/ur got %b%b%b%b%b%b required %b%b%b%b%b%b",
               ec, px, py, pixel, active, hsync, vsync, frame_start, underrun,
               ep, ea, eh, ev, ef, exp_under);
    end
  endtask

  // Called at a falling edge: drive inputs for the next rising edge,
  // run the memory and the model, then sample at the following fall.
  task automatic step(input bit rst, input bit en);
    int e, lat;
    reset_n  = !rst;
    enable   = en;
    e        = ec + 1;
    rd_valid = 1'b0;
    rd_data  = '0;
    last_req = 1'b0;
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].due == e) begin
        rd_valid = 1'b1;
        rd_data  = mem[pend[i].idx];
        arrival[pend[i].idx] = e;
        pend.delete(i);
        break;
      end
    end
    #1;
    if (rd_req && !rst) begin
      if (rd_addr < 15'h4000 || rd_addr > 15'h5FFF) addr_bad++;
      chk("one_outstanding", pend.size(), 0);
      lat = (lat_force > 0) ? lat_force : int'($urandom_range(lat_max, 1));
      lat_force = 0;
      last_req = 1'b1;
      pend.push_back('{e + lat, int'(rd_addr) - 16384});
    end
    ec = e;
    model_edge(rst, en, e);
    @(negedge clock);
    if (checking) check_outputs();
  endtask

  initial begin
    int n, vs, a, h, f, orr;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 16'($urandom);
      arrival[i] = NEVER;
    end
    mem[0] = 16'h0001;
    mem[8191] = 16'h8000;
    @(negedge clock);
    step(1, 1);
    checking = 1'b1;
    step(1, 1);
    step(1, 1);
    chk("reset_vsync", int'(vsync), 1);
    chk("reset_active", int'(active), 0);
    chk("reset_hsync", int'(hsync), 0);
    chk("reset_fs", int'(frame_start), 0);
    chk("reset_underrun", int'(underrun), 0);
    chk("reset_pixel", int'(pixel), 0);
    chk("reset_rd_req", int'(rd_req), 0);

    n = 0;
    vs = int'(vsync);
    while (!frame_start && n < 6000) begin
      step(0, 1);
      n++;
      vs += int'(vsync);
    end
    chk("fs_after_vblank", n, 4352);
    chk("vsync_clocks", vs, 4352);
    chk("pixel_0_0", int'(pixel), 1);
    a = int'(active);
    h = int'(hsync);
    f = int'(frame_start);
    orr = 0;
    for (int i = 1; i < XT; i++) begin
      step(0, 1);
      if (i < 16) orr |= int'(pixel);
      a += int'(active);
      h += int'(hsync);
      f += int'(frame_start);
    end
    chk("pixel_1_15", orr, 0);
    chk("active_per_line", a, 512);
    chk("hsync_per_line", h, 32);
    chk("fs_per_line", f, 1);

    lat_max = 4;
    for (int i = 0; i < 3 * XT; i++) step(0, 1);

    for (int i = 0; i < 8 * XT; i++) step(0, ($urandom_range(9, 0) != 0));

    n = 0;
    while (px != 200 && n < 2000) begin
      step(0, 1);
      n++;
    end
    chk("reach_x200", int'(n < 2000), 1);
    for (int i = 0; i < 10; i++) step(0, 0);
    for (int i = 0; i < 2 * XT; i++) step(0, 1);
    chk("no_underrun_yet", int'(underrun), 0);

    lat_max = 1;
    n = 0;
    while (!(px == 100 && py < 256) && n < 2000) begin
      step(0, 1);
      n++;
    end
    lat_force = 20;
    for (int i = 0; i < 2 * XT; i++) step(0, 1);
    chk("underrun_set", int'(underrun), 1);

    lat_force = 2;
    n = 0;
    do begin
      step(0, 1);
      n++;
    end while (!last_req && n < 100);
    chk("req_before_reset", int'(last_req), 1);
    step(1, 1);
    chk("underrun_cleared", int'(underrun), 0);
    n = 0;
    while (!frame_start && n < 6000) begin
      step(0, 1);
      n++;
    end
    chk("fs_after_reset", n, 4352);
    for (int i = 0; i < 3 * XT; i++) step(0, 1);
    chk("no_underrun_after_reset", int'(underrun), 0);
    chk("addr_range", addr_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
